xbus_grant_arbiter: RTL and testbench
=====================================

// Module: xbus_grant_arbiter
// PURPOSE
//  Shares one bus/resource among 4 requesters; grants exactly one at a time.
//  Registered, sequenced replacement for the open-coded 4-group and-or-invert
//  grant logic in the memory/Xbus control path.
//  Modes: round-robin or fixed priority; per-grant watchdog; one dead cycle
//  between successive grants.
// PARAMETERS
//  PRI_MODE  0    0 = round-robin, 1 = fixed priority (req[0] highest)
//  TIMEOUT   200  max cycles a grant may stay high; 0 = watchdog disabled
//  CNT_W     8    watchdog counter width; TIMEOUT must be < 2**CNT_W
// PORTS
//  clk       in   1  system clock, all state on rising edge
//  reset     in   1  synchronous, active-high
//  req       in   4  level requests; held high for the whole bus tenure
//  grant     out  4  one-hot or zero, registered
//  owner     out  2  index of granted requester; valid only while busy=1
//  busy      out  1  =|grant
//  timeout   out  1  one-cycle pulse when the watchdog forces a release
//  lockout   out  4  requesters barred after a timeout
// BEHAVIOUR
//  Reset: grant=0, owner=0, busy=0, timeout=0, lockout=0, state=IDLE,
//   rr pointer last=3, so the first round-robin search starts at req[0].
//  Eligible: elig[i] = req[i] & ~lockout[i].
//  States: IDLE, GRANT, RECOVER.
//  IDLE: if |elig at edge t, pick winner, enter GRANT; grant[w]=1 from t+1.
//   Zero-cycle latency in decision; one-cycle latency to the grant output.
//  Pick, RR: first elig index scanning last+1, last+2, ... mod 4 (wraps 3->0).
//   Pick, fixed priority: lowest elig index. last := winner on every grant.
//  GRANT: cnt clears on entry, then increments once per cycle grant is high.
//   - req[owner]=0: next edge -> RECOVER, grant=0.
//   - else TIMEOUT!=0 and cnt==TIMEOUT-1: next edge -> RECOVER, grant=0,
//     timeout=1 for that one cycle, lockout[owner]=1.
//   - Release and timeout on the same cycle: release wins, no timeout.
//   - Other reqs rising during GRANT have no effect (no preemption).
//  RECOVER: exactly one cycle with grant=0 (bus turnaround), then arbitrate
//   as IDLE. Winner granted -> GRANT, else -> IDLE. Minimum gap between
//   grants is 1 cycle.
//  Lockout: lockout[i] clears on any edge where req[i]=0. A set lockout
//   persists while req[i] stays high.
//  Grant never high for TIMEOUT+1 cycles. Never more than one grant bit set.
//  reset mid-tenure: grant drops on the edge reset is sampled; all state is
//   reinitialised.
//  No combinational path from req to any output.
// TESTING
//  1 Reset, then req=0001 at t0 -> grant=0001 at t0+1, owner=0, busy=1;
//    drop req at t5 -> grant=0000 at t6.
//  2 RR: req=1111 held, each owner drops req 3 cycles after its grant,
//    then reasserts -> grant order 0,1,2,3,0 with 1 dead cycle between grants.
//  3 PRI_MODE=1, req=1110 then req[1] released/reasserted
//    -> req[1] wins each time, req[3] never granted.
//  4 TIMEOUT=4, req=0100 held -> grant high 4 cycles, then timeout pulse,
//    lockout=0100, no regrant; drop req[2] 1 cycle -> lockout clears;
//    reassert -> granted.
//  5 Release and timeout in the same cycle (TIMEOUT=4, req drops on 4th
//    grant cycle) -> timeout stays 0, lockout stays 0.
//  6 reset pulsed while grant=1000 -> grant=0 next cycle; after reset with
//    req=1001, RR -> req[0] granted first.

Source files
------------

// File: rtl/xbus_grant_arbiter.sv
// Four-requester bus arbiter: round-robin or fixed priority, registered grant,
// one turnaround cycle between tenures and a per-grant watchdog with lockout.
module xbus_grant_arbiter #(
    parameter int unsigned PRI_MODE = 0,
    parameter int unsigned TIMEOUT  = 200,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout,
    output logic [3:0] lockout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RECOVER
    } state_t;

    localparam logic [CNT_W-1:0] TO_CNT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic [3:0]       lockout_q, lockout_d;

    logic [3:0]       elig;
    logic [1:0]       win;
    logic             found;
    logic [1:0]       idx;

    assign elig = req & ~lockout_q;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        if (PRI_MODE != 0) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (!found && elig[i]) begin
                    win   = 2'(i);
                    found = 1'b1;
                end
            end
        end else begin
            // Search begins one past the previous winner and wraps 3 -> 0.
            for (int unsigned k = 1; k <= 4; k++) begin
                idx = 2'(last_q + 2'(k));
                if (!found && elig[idx]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        lockout_d = lockout_q & req;
        case (state_q)
            S_IDLE, S_RECOVER: begin
                if (found) begin
                    state_d = S_GRANT;
                    grant_d = 4'b0001 << win;
                    owner_d = win;
                    last_d  = win;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
            S_GRANT: begin
                // A release on the watchdog's final cycle takes precedence.
                if (!req[owner_q]) begin
                    state_d = S_RECOVER;
                    grant_d = '0;
                end else if (TIMEOUT != 0 && cnt_q == TO_CNT) begin
                    state_d            = S_RECOVER;
                    grant_d            = '0;
                    timeout_d          = 1'b1;
                    lockout_d[owner_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            last_q    <= 2'd3;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            lockout_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            lockout_q <= lockout_d;
        end
    end

    assign grant   = grant_q;
    assign owner   = owner_q;
    assign busy    = |grant_q;
    assign timeout = timeout_q;
    assign lockout = lockout_q;

endmodule

// File: tb/tb_xbus_grant_arbiter.sv
// Directed bench for xbus_grant_arbiter: round-robin, fixed-priority and
// short-watchdog instances driven step by step against hand-computed values.
module tb_xbus_grant_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req_a = '0, req_b = '0, req_c = '0;

    logic [3:0] grant_a, grant_b, grant_c;
    logic [1:0] owner_a, owner_b, owner_c;
    logic       busy_a, busy_b, busy_c;
    logic       to_a, to_b, to_c;
    logic [3:0] lock_a, lock_b, lock_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xbus_grant_arbiter #(.PRI_MODE(0), .TIMEOUT(200), .CNT_W(8)) dut_rr (
        .clk(clk), .reset(reset), .req(req_a), .grant(grant_a), .owner(owner_a),
        .busy(busy_a), .timeout(to_a), .lockout(lock_a)
    );

    xbus_grant_arbiter #(.PRI_MODE(1), .TIMEOUT(200), .CNT_W(8)) dut_fp (
        .clk(clk), .reset(reset), .req(req_b), .grant(grant_b), .owner(owner_b),
        .busy(busy_b), .timeout(to_b), .lockout(lock_b)
    );

    xbus_grant_arbiter #(.PRI_MODE(0), .TIMEOUT(4), .CNT_W(8)) dut_to (
        .clk(clk), .reset(reset), .req(req_c), .grant(grant_c), .owner(owner_c),
        .busy(busy_c), .timeout(to_c), .lockout(lock_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_g;

        // Reset and single requester
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_grant", 8'(grant_a), 8'h0);
        chk("rst_owner", 8'(owner_a), 8'h0);
        chk("rst_busy", 8'(busy_a), 8'h0);
        chk("rst_timeout", 8'(to_c), 8'h0);
        chk("rst_lockout", 8'(lock_c), 8'h0);
        req_a = 4'b0001;
        step();
        chk("t1_grant", 8'(grant_a), 8'h01);
        chk("t1_owner", 8'(owner_a), 8'h0);
        chk("t1_busy", 8'(busy_a), 8'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_hold", 8'(grant_a), 8'h01);
        end
        req_a = 4'b0000;
        step();
        chk("t1_release", 8'(grant_a), 8'h0);
        chk("t1_release_busy", 8'(busy_a), 8'h0);
        step();
        chk("t1_idle", 8'(grant_a), 8'h0);

        // Round-robin rotation with dead cycle between grants
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_a = 4'b1111;
        step();
        for (int n = 0; n < 5; n++) begin
            exp_g = 4'b0001 << (n % 4);
            chk("t2_grant", 8'(grant_a), 8'(exp_g));
            chk("t2_owner", 8'(owner_a), 8'(n % 4));
            step();
            chk("t2_hold1", 8'(grant_a), 8'(exp_g));
            step();
            chk("t2_hold2", 8'(grant_a), 8'(exp_g));
            req_a[n % 4] = 1'b0;
            step();
            chk("t2_dead", 8'(grant_a), 8'h0);
            req_a[n % 4] = 1'b1;
            step();
        end
        req_a = 4'b0000;
        step();
        step();

        // Fixed priority: req[1] always beats req[2] and req[3]
        req_b = 4'b1110;
        step();
        for (int n = 0; n < 3; n++) begin
            chk("t3_grant", 8'(grant_b), 8'h02);
            chk("t3_owner", 8'(owner_b), 8'h1);
            step();
            chk("t3_hold", 8'(grant_b), 8'h02);
            req_b[1] = 1'b0;
            step();
            chk("t3_dead", 8'(grant_b), 8'h0);
            req_b[1] = 1'b1;
            step();
        end
        req_b = 4'b0000;
        step();
        step();

        // Watchdog timeout and lockout
        req_c = 4'b0100;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("t4_grant", 8'(grant_c), 8'h04);
            chk("t4_no_to", 8'(to_c), 8'h0);
            if (i < 3) step();
        end
        step();
        chk("t4_drop", 8'(grant_c), 8'h0);
        chk("t4_timeout", 8'(to_c), 8'h1);
        chk("t4_lockout", 8'(lock_c), 8'h04);
        step();
        chk("t4_to_pulse", 8'(to_c), 8'h0);
        chk("t4_no_regrant", 8'(grant_c), 8'h0);
        chk("t4_lock_hold", 8'(lock_c), 8'h04);
        step();
        chk("t4_no_regrant2", 8'(grant_c), 8'h0);
        req_c = 4'b0000;
        step();
        chk("t4_lock_clear", 8'(lock_c), 8'h0);
        req_c = 4'b0100;
        step();
        chk("t4_regrant", 8'(grant_c), 8'h04);
        req_c = 4'b0000;
        step();
        chk("t4_release", 8'(grant_c), 8'h0);
        step();

        // Release on the watchdog's final cycle: no timeout, no lockout
        req_c = 4'b0100;
        step();
        chk("t5_grant", 8'(grant_c), 8'h04);
        step();
        step();
        step();
        chk("t5_grant4", 8'(grant_c), 8'h04);
        req_c = 4'b0000;
        step();
        chk("t5_release", 8'(grant_c), 8'h0);
        chk("t5_timeout", 8'(to_c), 8'h0);
        chk("t5_lockout", 8'(lock_c), 8'h0);
        step();
        chk("t5_timeout2", 8'(to_c), 8'h0);
        chk("t5_lockout2", 8'(lock_c), 8'h0);

        // Reset mid-tenure
        req_a = 4'b1000;
        step();
        step();
        chk("t6_grant", 8'(grant_a), 8'h08);
        chk("t6_owner", 8'(owner_a), 8'h3);
        reset = 1'b1;
        req_a = 4'b1001;
        step();
        chk("t6_rst_grant", 8'(grant_a), 8'h0);
        chk("t6_rst_busy", 8'(busy_a), 8'h0);
        reset = 1'b0;
        step();
        chk("t6_rr_first", 8'(grant_a), 8'h01);
        chk("t6_rr_owner", 8'(owner_a), 8'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
